rom_read_arbiter: RTL

Shares one synchronous-read sprite/title ROM port among several requesters. Requester 0 is the display pixel pipeline and has absolute priority. Requesters 1..NREQ-1 (sprite loaders, score/text generators) are served round-robin in cycles the display leaves idle. The block sits between the requesters and the ROM's `pixel_addr` / `rgbmap` port. It registers the winning address and returns the ROM data to the requester that issued it, tagged with a valid pulse.

---
 rtl/rom_read_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/rom_read_arbiter.sv
// rtl/rom_read_arbiter.sv - shared sync-read ROM port: display priority, round-robin for the rest
// Two-stage tag pipeline tracks which requester owns the word coming back from the ROM.
module rom_read_arbiter #(
    parameter int NREQ      = 3,
    parameter int ADDR_BITS = 15,
    parameter int DATA_BITS = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*ADDR_BITS-1:0] addr,
    output logic [NREQ-1:0]           gnt,
    output logic [ADDR_BITS-1:0]      rom_addr,
    input  logic [DATA_BITS-1:0]      rom_data,
    output logic [NREQ-1:0]           rvalid,
    output logic [DATA_BITS-1:0]      rdata,
    output logic                      busy
);

    localparam int IDX_BITS = $clog2(NREQ);
    localparam int CW       = IDX_BITS + 1;

    logic [IDX_BITS-1:0]  rr_ptr;
    logic [IDX_BITS-1:0]  nxt_ptr;
    logic                 win_any;
    logic [IDX_BITS-1:0]  win_idx;
    logic [CW-1:0]        cand;
    logic [NREQ-1:0]      win_onehot;
    logic [ADDR_BITS-1:0] win_addr;

    logic                 s1_valid;
    logic [IDX_BITS-1:0]  s1_idx;
    logic                 s2_valid;
    logic [IDX_BITS-1:0]  s2_idx;

    // Port 0 preempts; otherwise scan from rr_ptr upward, wrapping back to 1 (never to 0).
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        cand    = '0;
        if (req[0]) begin
            win_any = 1'b1;
        end else begin
            for (int k = 0; k < NREQ - 1; k++) begin
                cand = {1'b0, rr_ptr} + CW'(k);
                if (cand > CW'(NREQ - 1))
                    cand = cand - CW'(NREQ - 1);
                if (!win_any && req[cand[IDX_BITS-1:0]]) begin
                    win_any = 1'b1;
                    win_idx = cand[IDX_BITS-1:0];
                end
            end
        end
    end

    always_comb begin
        nxt_ptr = (win_idx == IDX_BITS'(NREQ - 1)) ? IDX_BITS'(1) : win_idx + IDX_BITS'(1);
    end

    always_comb begin
        win_onehot = '0;
        win_addr   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_any && win_idx == IDX_BITS'(i)) begin
                win_onehot[i] = 1'b1;
                win_addr      = addr[i*ADDR_BITS +: ADDR_BITS];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt      <= '0;
            rom_addr <= '0;
            rr_ptr   <= IDX_BITS'(1);
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s2_valid <= 1'b0;
            s2_idx   <= '0;
        end else begin
            gnt      <= win_onehot;
            s1_valid <= win_any;
            s1_idx   <= win_idx;
            s2_valid <= s1_valid;
            s2_idx   <= s1_idx;
            if (win_any)
                rom_addr <= win_addr;
            if (win_any && !req[0])
                rr_ptr <= nxt_ptr;
        end
    end

    // The ROM samples rom_addr on the same edge the tag moves to stage 2.
    always_comb begin
        rvalid = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (s2_valid && s2_idx == IDX_BITS'(i))
                rvalid[i] = 1'b1;
        end
    end

    assign rdata = rom_data;
    assign busy  = s1_valid | s2_valid;

endmodule
